lock_arbiter_rr: RTL and testbench

LOCK_ARBITER_RR -- requirements
Module: lock_arbiter_rr

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_select.sv | 26 ++
 rtl/lock_arbiter_rr.sv | 137 +++++++++++++
 tb/tb_lock_arbiter_rr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin lock arbiter.
package arb_pkg;

  localparam int OWNER_W = 3;
  localparam int WDOG_W  = 8;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQUEST = 2'd1,
    HS_LOCK    = 2'd2,
    HS_RELEASE = 2'd3
  } hs_e;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RECLAIM = 2'd3
  } arb_state_e;

  // Idle counts as leaving too: a requester that abandons the lock gives it back.
  function automatic logic isLeaving(input hs_e hs);
    return (hs == HS_RELEASE) || (hs == HS_IDLE);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requesting index after last_i, wrapping.
module rr_select
  import arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] last_i,
  output logic               valid_o,
  output logic [OWNER_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid_o && req_i[j] && (j == ((int'(last_i) + i) % N_REQ))) begin
          valid_o = 1'b1;
          idx_o   = OWNER_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/lock_arbiter_rr.sv
// Round-robin lock arbiter with handshake FSM; define LOCK_WATCHDOG_EN to
// build the ownership watchdog that force-revokes long-held locks.
module lock_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WDOG_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_REQ-1:0]   req_state,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     revoke,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 wdog_err
);

  if (N_REQ < 2 || N_REQ > 8 || WDOG_MAX < 1 || WDOG_MAX > 255) begin : gBadParams
    $error("lock_arbiter_rr: parameter out of range");
  end

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] last_owner_q, last_owner_d;
  logic [N_REQ-1:0]   ack_q, ack_d;

  logic [N_REQ-1:0]   reqVec;
  hs_e                ownerHs;
  logic               ownerLeaving;
  logic               selValid;
  logic [OWNER_W-1:0] selIdx;
  logic               expire;

  function automatic logic [N_REQ-1:0] oneHot(input logic [OWNER_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int j = 0; j < N_REQ; j++) v[j] = (OWNER_W'(j) == idx);
    return v;
  endfunction

  always_comb begin
    reqVec  = '0;
    ownerHs = HS_IDLE;
    for (int j = 0; j < N_REQ; j++) begin
      reqVec[j] = (req_state[2*j +: 2] == HS_REQUEST);
      if (OWNER_W'(j) == owner_q) ownerHs = hs_e'(req_state[2*j +: 2]);
    end
    ownerLeaving = isLeaving(ownerHs);
  end

  rr_select #(.N_REQ(N_REQ)) uSelect (
    .req_i  (reqVec),
    .last_i (last_owner_q),
    .valid_o(selValid),
    .idx_o  (selIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FREE;
      owner_q      <= '0;
      last_owner_q <= OWNER_W'(N_REQ - 1);
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (selValid) state_d = GRANT;
      GRANT:   state_d = OWNED;
      OWNED:   if (ownerLeaving || expire) state_d = RECLAIM;
      RECLAIM: state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // ack is computed one cycle early so it is a clean register during GRANT.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ack_d        = '0;
    if (state_q == FREE && selValid) begin
      owner_d = selIdx;
      ack_d   = oneHot(selIdx);
    end
    if (state_q == RECLAIM) last_owner_d = owner_q;
  end

  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT) || (state_q == OWNED);

`ifdef LOCK_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic [N_REQ-1:0]  revoke_q, revoke_d;
  logic              wdog_err_q, wdog_err_d;
  logic              forceRevoke;

  // A release arriving in the expiry cycle wins: no revoke, no error.
  always_comb begin
    expire      = (state_q == OWNED) && ({1'b0, wdog_cnt_q} == 9'(WDOG_MAX - 1));
    forceRevoke = expire && !ownerLeaving;
    wdog_cnt_d  = wdog_cnt_q;
    if (state_q == GRANT)      wdog_cnt_d = '0;
    else if (state_q == OWNED) wdog_cnt_d = wdog_cnt_q + 1'b1;
    revoke_d   = forceRevoke ? oneHot(owner_q) : '0;
    wdog_err_d = wdog_err_q | forceRevoke;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      revoke_q   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      revoke_q   <= revoke_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign revoke   = revoke_q;
  assign wdog_err = wdog_err_q;
`else
  assign expire   = 1'b0;
  assign revoke   = '0;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_lock_arbiter_rr.sv
// Directed self-checking bench for lock_arbiter_rr (N_REQ=4, WDOG_MAX=4).
module tb_lock_arbiter_rr;
  import arb_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [2*N-1:0] reqState;
  logic [N-1:0] ack;
  logic [N-1:0] revoke;
  logic [2:0]   owner;
  logic         busy;
  logic         wdogErr;

  int checkCount = 0;
  int errorCount = 0;

  lock_arbiter_rr #(.N_REQ(N), .WDOG_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_state(reqState),
    .ack      (ack),
    .revoke   (revoke),
    .owner    (owner),
    .busy     (busy),
    .wdog_err (wdogErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input hs_e v);
    reqState[2*idx +: 2] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    reqState = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps at least once, then until ack shows up or the budget runs out.
  task automatic waitAck(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < 8);
    checkOutput({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
  endtask

  initial begin
    int expOrder[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    reqState = '0;
    #12;
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_revoke", 32'(revoke), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_wdog", 32'(wdogErr), 32'h0);
    step();
    rst = 1'b0;

    // Single requester: grant one cycle after request, release frees next cycle
    step();
    applyStimulus(0, HS_REQUEST);
    step();
    checkOutput("single_ack", 32'(ack), 32'h1);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_owner", 32'(owner), 32'h0);
    applyStimulus(0, HS_LOCK);
    step();
    checkOutput("single_ack_pulse", 32'(ack), 32'h0);
    checkOutput("single_owned_busy", 32'(busy), 32'h1);
    step();
    step();
    applyStimulus(0, HS_RELEASE);
    step();
    checkOutput("single_release_busy", 32'(busy), 32'h0);
    applyStimulus(0, HS_IDLE);
    step();
    checkOutput("single_free_busy", 32'(busy), 32'h0);

    // All four requesting: round-robin order 0,1,2,3,0
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, HS_REQUEST);
    for (int g = 0; g < 5; g++) begin
      waitAck($sformatf("rr%0d", g));
      checkOutput($sformatf("rr%0d_ack", g), 32'(ack), 32'(1) << expOrder[g]);
      checkOutput($sformatf("rr%0d_owner", g), 32'(owner), 32'(expOrder[g]));
      applyStimulus(expOrder[g], HS_LOCK);
      step();
      step();
      checkOutput($sformatf("rr%0d_hold_busy", g), 32'(busy), 32'h1);
      applyStimulus(expOrder[g], HS_RELEASE);
      step();
      checkOutput($sformatf("rr%0d_reclaim_busy", g), 32'(busy), 32'h0);
      applyStimulus(expOrder[g], HS_REQUEST);
    end
    reqState = '0;
    step();

    // Owner 2 abandons (idle): reclaim without revoke, next grant to 3
    applyStimulus(2, HS_REQUEST);
    waitAck("abandon");
    checkOutput("abandon_ack", 32'(ack), 32'h4);
    applyStimulus(2, HS_LOCK);
    applyStimulus(3, HS_REQUEST);
    step();
    checkOutput("abandon_nonowner_ignored", 32'(ack), 32'h0);
    applyStimulus(2, HS_IDLE);
    step();
    checkOutput("abandon_reclaim_busy", 32'(busy), 32'h0);
    checkOutput("abandon_no_revoke", 32'(revoke), 32'h0);
    step();
    step();
    checkOutput("abandon_next_ack", 32'(ack), 32'h8);
    checkOutput("abandon_next_owner", 32'(owner), 32'h3);

    // Async reset while requester 3 owns: everything clears immediately
    applyStimulus(3, HS_LOCK);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_ack", 32'(ack), 32'h0);
    checkOutput("midrst_revoke", 32'(revoke), 32'h0);
    checkOutput("midrst_owner", 32'(owner), 32'h0);
    step();
    rst = 1'b0;
    applyStimulus(0, HS_REQUEST);
    applyStimulus(3, HS_REQUEST);
    waitAck("postrst");
    checkOutput("postrst_ack", 32'(ack), 32'h1);

    // Release coinciding with the 4th owned cycle counts as a release
    doReset();
    applyStimulus(1, HS_REQUEST);
    waitAck("tie");
    applyStimulus(1, HS_LOCK);
    for (int k = 0; k < 4; k++) step();
    applyStimulus(1, HS_RELEASE);
    step();
    checkOutput("tie_busy", 32'(busy), 32'h0);
    checkOutput("tie_revoke", 32'(revoke), 32'h0);
    checkOutput("tie_wdog", 32'(wdogErr), 32'h0);

    // Owner 1 holds lock forever
    doReset();
    applyStimulus(1, HS_REQUEST);
    waitAck("hold");
    checkOutput("hold_ack", 32'(ack), 32'h2);
    applyStimulus(1, HS_LOCK);
    for (int k = 0; k < 4; k++) step();
    checkOutput("hold_4th_busy", 32'(busy), 32'h1);
    checkOutput("hold_4th_revoke", 32'(revoke), 32'h0);
    step();
`ifdef LOCK_WATCHDOG_EN
    checkOutput("wdog_revoke", 32'(revoke), 32'h2);
    checkOutput("wdog_busy", 32'(busy), 32'h0);
    checkOutput("wdog_err_set", 32'(wdogErr), 32'h1);
    step();
    checkOutput("wdog_revoke_pulse", 32'(revoke), 32'h0);
    for (int k = 0; k < 5; k++) step();
    checkOutput("wdog_err_sticky", 32'(wdogErr), 32'h1);
`else
    checkOutput("nowdog_revoke", 32'(revoke), 32'h0);
    checkOutput("nowdog_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 20; k++) step();
    checkOutput("nowdog_busy_late", 32'(busy), 32'h1);
    checkOutput("nowdog_owner", 32'(owner), 32'h1);
    checkOutput("nowdog_err", 32'(wdogErr), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
